// File: rtl/mem_router.sv
// mem_router: routes one CPU memory request at a time to port 0 or port 1 by word-index range.
// Build option MEM_ROUTER_ALIGN_CHECK_EN rejects misaligned half/word requests before decode.

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 2
`define MEM_COUNT_NONE 2'd0
`define MEM_COUNT_BYTE 2'd1
`define MEM_COUNT_HALF 2'd2
`define MEM_COUNT_WORD 2'd3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 3
`define MEM_CODE_INVALID 3'd0
`define MEM_CODE_READ 3'd1
`define MEM_CODE_WRITE 3'd2
`define MEM_CODE_MISALIGNED 3'd3
`define MEM_CODE_FAULT 3'd4
`endif

module mem_router #(
  parameter int unsigned P0_ADDR_START = 0,
  parameter int unsigned P0_ADDR_END   = 1,
  parameter int unsigned P1_ADDR_START = 1,
  parameter int unsigned P1_ADDR_END   = 2
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic [`ADDR_W-1:0]      i_req_addr,
  input  logic [`MEM_COUNT_W-1:0] i_req_count,
  input  logic [`WORD_W-1:0]      i_req_wr_data,
  output logic                    o_ready,
  output logic                    o_res_valid,
  output logic [`WORD_W-1:0]      o_res_rd_data,
  output logic [`MEM_CODE_W-1:0]  o_res_code,
  output logic [`ADDR_W-1:0]      o_p0_req_addr,
  output logic [`MEM_COUNT_W-1:0] o_p0_req_count,
  output logic [`WORD_W-1:0]      o_p0_req_wr_data,
  input  logic [`WORD_W-1:0]      i_p0_res_rd_data,
  input  logic [`MEM_CODE_W-1:0]  i_p0_res_code,
  output logic [`ADDR_W-1:0]      o_p1_req_addr,
  output logic [`MEM_COUNT_W-1:0] o_p1_req_count,
  output logic [`WORD_W-1:0]      o_p1_req_wr_data,
  input  logic [`WORD_W-1:0]      i_p1_res_rd_data,
  input  logic [`MEM_CODE_W-1:0]  i_p1_res_code
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [`ADDR_W-1:0] P0_LO   = `ADDR_W'(P0_ADDR_START);
  localparam logic [`ADDR_W-1:0] P0_HI   = `ADDR_W'(P0_ADDR_END);
  localparam logic [`ADDR_W-1:0] P1_LO   = `ADDR_W'(P1_ADDR_START);
  localparam logic [`ADDR_W-1:0] P1_HI   = `ADDR_W'(P1_ADDR_END);
  localparam logic [`ADDR_W-1:0] P0_SPAN = (P0_HI > P0_LO) ? P0_HI - P0_LO : '0;
  localparam logic [`ADDR_W-1:0] P1_SPAN = (P1_HI > P1_LO) ? P1_HI - P1_LO : '0;
  localparam logic [`ADDR_W-1:0] P0_BASE = P0_LO << 2;
  localparam logic [`ADDR_W-1:0] P1_BASE = P1_LO << 2;

  state_t             state;
  logic               sel_p1;
  logic [`ADDR_W-1:0] word_idx;
  logic               p0_hit;
  logic               p1_hit;
  logic               misaligned;

  // Range test as unsigned offset < span, which covers both bounds in one compare.
  always_comb begin
    word_idx = {2'b00, i_req_addr[`ADDR_W-1:2]};
    p0_hit   = (word_idx - P0_LO) < P0_SPAN;
    p1_hit   = (word_idx - P1_LO) < P1_SPAN;
`ifdef MEM_ROUTER_ALIGN_CHECK_EN
    misaligned = ((i_req_count == `MEM_COUNT_HALF) && i_req_addr[0]) ||
                 ((i_req_count == `MEM_COUNT_WORD) && (i_req_addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
  end

  // The port request registers double as the accepted-request latch.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state            <= IDLE;
      sel_p1           <= 1'b0;
      o_ready          <= 1'b1;
      o_res_valid      <= 1'b0;
      o_res_rd_data    <= '0;
      o_res_code       <= `MEM_CODE_INVALID;
      o_p0_req_addr    <= '0;
      o_p0_req_count   <= `MEM_COUNT_NONE;
      o_p0_req_wr_data <= '0;
      o_p1_req_addr    <= '0;
      o_p1_req_count   <= `MEM_COUNT_NONE;
      o_p1_req_wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_count != `MEM_COUNT_NONE) begin
            o_ready <= 1'b0;
            if (misaligned) begin
              state         <= RESP;
              o_res_valid   <= 1'b1;
              o_res_rd_data <= '0;
              o_res_code    <= `MEM_CODE_MISALIGNED;
            end else if (p0_hit) begin
              state            <= ISSUE;
              sel_p1           <= 1'b0;
              o_p0_req_count   <= i_req_count;
              o_p0_req_addr    <= i_req_addr - P0_BASE;
              o_p0_req_wr_data <= i_req_wr_data;
            end else if (p1_hit) begin
              state            <= ISSUE;
              sel_p1           <= 1'b1;
              o_p1_req_count   <= i_req_count;
              o_p1_req_addr    <= i_req_addr - P1_BASE;
              o_p1_req_wr_data <= i_req_wr_data;
            end else begin
              state         <= RESP;
              o_res_valid   <= 1'b1;
              o_res_rd_data <= '0;
              o_res_code    <= `MEM_CODE_INVALID;
            end
          end
        end
        ISSUE: begin
          state          <= WAIT;
          o_p0_req_count <= `MEM_COUNT_NONE;
          o_p1_req_count <= `MEM_COUNT_NONE;
        end
        WAIT: begin
          state         <= RESP;
          o_res_valid   <= 1'b1;
          o_res_rd_data <= sel_p1 ? i_p1_res_rd_data : i_p0_res_rd_data;
          o_res_code    <= sel_p1 ? i_p1_res_code : i_p0_res_code;
        end
        RESP: begin
          state       <= IDLE;
          o_res_valid <= 1'b0;
          o_ready     <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          o_res_valid <= 1'b0;
          o_ready     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_router.sv
// tb_mem_router: directed plus randomized transactions against a transaction-level reference model.
// Port map under test: port 0 = word indices [0,4), port 1 = [4,8); everything else unmapped.

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 2
`define MEM_COUNT_NONE 2'd0
`define MEM_COUNT_BYTE 2'd1
`define MEM_COUNT_HALF 2'd2
`define MEM_COUNT_WORD 2'd3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 3
`define MEM_CODE_INVALID 3'd0
`define MEM_CODE_READ 3'd1
`define MEM_CODE_WRITE 3'd2
`define MEM_CODE_MISALIGNED 3'd3
`define MEM_CODE_FAULT 3'd4
`endif

module tb_mem_router;
  localparam int P0S = 0;
  localparam int P0E = 4;
  localparam int P1S = 4;
  localparam int P1E = 8;

  logic                    clk = 1'b0;
  logic                    aresetn = 1'b1;
  logic [`ADDR_W-1:0]      req_addr = '0;
  logic [`MEM_COUNT_W-1:0] req_count = `MEM_COUNT_NONE;
  logic [`WORD_W-1:0]      req_wr = '0;
  logic                    ready, res_valid;
  logic [`WORD_W-1:0]      res_rd;
  logic [`MEM_CODE_W-1:0]  res_code;
  logic [`ADDR_W-1:0]      p0_addr, p1_addr;
  logic [`MEM_COUNT_W-1:0] p0_count, p1_count;
  logic [`WORD_W-1:0]      p0_wr, p1_wr;
  logic [`WORD_W-1:0]      p0_rd = '0, p1_rd = '0;
  logic [`MEM_CODE_W-1:0]  p0_code = '0, p1_code = '0;

  int unsigned n_cmp = 0, n_bad = 0;
  int unsigned pulses = 0, exp_pulses = 0;
  logic [`WORD_W-1:0]     last_d = '0;
  logic [`MEM_CODE_W-1:0] last_c = `MEM_CODE_INVALID;

  always #5 clk = ~clk;

  mem_router #(
    .P0_ADDR_START(P0S), .P0_ADDR_END(P0E),
    .P1_ADDR_START(P1S), .P1_ADDR_END(P1E)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .i_req_addr(req_addr), .i_req_count(req_count), .i_req_wr_data(req_wr),
    .o_ready(ready), .o_res_valid(res_valid), .o_res_rd_data(res_rd), .o_res_code(res_code),
    .o_p0_req_addr(p0_addr), .o_p0_req_count(p0_count), .o_p0_req_wr_data(p0_wr),
    .i_p0_res_rd_data(p0_rd), .i_p0_res_code(p0_code),
    .o_p1_req_addr(p1_addr), .o_p1_req_count(p1_count), .o_p1_req_wr_data(p1_wr),
    .i_p1_res_rd_data(p1_rd), .i_p1_res_code(p1_code)
  );

  // Peripherals register a response for every cycle their request count is non-NONE.
  always @(posedge clk) begin
    if (p0_count != `MEM_COUNT_NONE) begin
      p0_rd   <= 32'hDEADBEEF ^ p0_addr ^ p0_wr;
      p0_code <= (p0_addr[1:0] != 2'b00) ? `MEM_CODE_FAULT : `MEM_CODE_READ;
    end
    if (p1_count != `MEM_COUNT_NONE) begin
      p1_rd   <= 32'hC0DE0000 ^ p1_addr ^ p1_wr;
      p1_code <= (p1_wr != '0) ? `MEM_CODE_WRITE : `MEM_CODE_READ;
    end
  end

  always @(negedge clk) if (res_valid === 1'b1) pulses++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [1:0] cnt, input logic [31:0] wd,
                                output int port, output logic [31:0] la, output logic [31:0] ed,
                                output logic [2:0] ec, output int lat);
    int idx;
    idx  = int'(a >> 2);
    port = -1; la = '0; ed = '0; ec = `MEM_CODE_INVALID; lat = 1;
`ifdef MEM_ROUTER_ALIGN_CHECK_EN
    if ((cnt == `MEM_COUNT_HALF && a[0]) || (cnt == `MEM_COUNT_WORD && a[1:0] != 2'b00)) begin
      ec = `MEM_CODE_MISALIGNED;
      return;
    end
`endif
    if (idx >= P0S && idx < P0E) port = 0;
    else if (idx >= P1S && idx < P1E) port = 1;
    if (port < 0) return;
    lat = 3;
    if (port == 0) begin
      la = a - 32'(P0S * 4);
      ed = 32'hDEADBEEF ^ la ^ wd;
      ec = (la % 4 != 0) ? `MEM_CODE_FAULT : `MEM_CODE_READ;
    end else begin
      la = a - 32'(P1S * 4);
      ed = 32'hC0DE0000 ^ la ^ wd;
      ec = (wd != 0) ? `MEM_CODE_WRITE : `MEM_CODE_READ;
    end
  endfunction

  // Called at a negedge; optionally leaves the next request presented right after acceptance.
  task automatic do_req(input logic [31:0] a, input logic [1:0] cnt, input logic [31:0] wd,
                        input logic hold, input logic [31:0] na, input logic [1:0] ncnt,
                        input logic [31:0] nwd);
    int port, lat, n;
    logic [31:0] la, ed;
    logic [2:0] ec;
    model(a, cnt, wd, port, la, ed, ec, lat);
    req_addr = a; req_count = cnt; req_wr = wd;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_wait", 64'(n < 20), 64'd1);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) begin req_addr = na; req_count = ncnt; req_wr = nwd; end
        else req_count = `MEM_COUNT_NONE;
      end
      check_eq("ready", ready, k == lat + 1);
      check_eq("res_valid", res_valid, k == lat);
      check_eq("p0_count", p0_count, (port == 0 && k == 1) ? cnt : `MEM_COUNT_NONE);
      check_eq("p1_count", p1_count, (port == 1 && k == 1) ? cnt : `MEM_COUNT_NONE);
      if (port == 0 && k == 1) begin
        check_eq("p0_addr", p0_addr, la);
        check_eq("p0_wr", p0_wr, wd);
      end
      if (port == 1 && k == 1) begin
        check_eq("p1_addr", p1_addr, la);
        check_eq("p1_wr", p1_wr, wd);
      end
      if (k == lat) begin
        last_d = ed; last_c = ec; exp_pulses++;
      end
      check_eq("res_data", res_rd, last_d);
      check_eq("res_code", res_code, last_c);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ready"}, ready, 1'b1);
    check_eq({tag, "_valid"}, res_valid, 1'b0);
    check_eq({tag, "_data"}, res_rd, 0);
    check_eq({tag, "_code"}, res_code, `MEM_CODE_INVALID);
    check_eq({tag, "_p0cnt"}, p0_count, `MEM_COUNT_NONE);
    check_eq({tag, "_p1cnt"}, p1_count, `MEM_COUNT_NONE);
    check_eq({tag, "_p0addr"}, p0_addr, 0);
    check_eq({tag, "_p1addr"}, p1_addr, 0);
    check_eq({tag, "_p0wr"}, p0_wr, 0);
    check_eq({tag, "_p1wr"}, p1_wr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra [0:60];
    logic [1:0]  rc [0:60];
    logic [31:0] rw [0:60];
    int idx;

    #2 aresetn = 1'b0;
    #1 check_reset_vals("rst_async");
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    #1 check_eq("ready_after_release", ready, 1'b1);
    last_d = '0; last_c = `MEM_CODE_INVALID;

    // No-request cycles must not start a transaction.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("idle_ready", ready, 1'b1);
      check_eq("idle_valid", res_valid, 1'b0);
      check_eq("idle_p0cnt", p0_count, `MEM_COUNT_NONE);
    end

    do_req(32'h0,   `MEM_COUNT_WORD, 32'h0, 1'b0, '0, '0, '0);
    do_req(32'h11,  `MEM_COUNT_BYTE, 32'h0, 1'b0, '0, '0, '0);
    do_req(32'h400, `MEM_COUNT_WORD, 32'h0, 1'b0, '0, '0, '0);
    do_req(32'h2,   `MEM_COUNT_WORD, 32'h0, 1'b0, '0, '0, '0);
    do_req(32'h5,   `MEM_COUNT_HALF, 32'h0, 1'b0, '0, '0, '0);
    do_req(32'h6,   `MEM_COUNT_HALF, 32'h0, 1'b0, '0, '0, '0);
    do_req(32'hC,   `MEM_COUNT_WORD, 32'h0, 1'b0, '0, '0, '0);
    do_req(32'h10,  `MEM_COUNT_WORD, 32'h0, 1'b0, '0, '0, '0);
    do_req(32'h1C,  `MEM_COUNT_WORD, 32'h0, 1'b0, '0, '0, '0);
    do_req(32'h20,  `MEM_COUNT_WORD, 32'h0, 1'b0, '0, '0, '0);
    do_req(32'h14,  `MEM_COUNT_WORD, 32'h12345678, 1'b0, '0, '0, '0);

    do_req(32'h8,  `MEM_COUNT_WORD, 32'hA5, 1'b1, 32'h18, `MEM_COUNT_HALF, 32'h5A);
    do_req(32'h18, `MEM_COUNT_HALF, 32'h5A, 1'b0, '0, '0, '0);

    // Reset during WAIT aborts the transaction.
    req_addr = 32'h4; req_count = `MEM_COUNT_WORD; req_wr = 32'h0;
    @(negedge clk);
    req_count = `MEM_COUNT_NONE;
    check_eq("abort_issue_p0cnt", p0_count, `MEM_COUNT_WORD);
    @(negedge clk);
    aresetn = 1'b0;
    #1 check_reset_vals("rst_wait");
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    #1 check_eq("ready_after_abort", ready, 1'b1);
    last_d = '0; last_c = `MEM_CODE_INVALID;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("no_resp_after_abort", res_valid, 1'b0);
    end
    check_eq("pulses_after_abort", pulses, exp_pulses);

    for (int i = 0; i <= 60; i++) begin
      idx   = int'($urandom_range(0, 10));
      if (idx == 10) idx = 32'h100;
      ra[i] = (32'(idx) << 2) | 32'($urandom_range(0, 3));
      rc[i] = 2'($urandom_range(1, 3));
      rw[i] = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
    end
    for (int i = 0; i < 60; i++)
      do_req(ra[i], rc[i], rw[i], 1'($urandom_range(0, 1)), ra[i + 1], rc[i + 1], rw[i + 1]);
    do_req(ra[60], rc[60], rw[60], 1'b0, '0, '0, '0);

    repeat (2) @(negedge clk);
    check_eq("pulse_count", pulses, exp_pulses);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
